// File: rtl/display_arbiter_if.sv
// Shared display-path bus between the round-robin arbiter (master) and its
// requesters plus the display write port (slave).
interface display_arbiter_if;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  ack;
  logic        disp_we;
  logic [15:0] disp_data;
  logic [1:0]  owner;
  logic        busy;

  modport master (
    input  req, req_data,
    output ack, disp_we, disp_data, owner, busy
  );

  modport slave (
    output req, req_data,
    input  ack, disp_we, disp_data, owner, busy
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter for the seven-segment display path: one write per grant,
// then the display is held for HOLD_CYCLES before the next requester may write.
module display_arbiter #(
  parameter int HOLD_CYCLES = 10000
) (
  input logic              clk,
  input logic              rst,
  display_arbiter_if.master bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last;
  logic [1:0]       sel;
  logic [1:0]       cand;
  logic             found;
  logic             grant;
  logic [15:0]      sel_word;

  logic [3:0]       ack_q;
  logic [3:0]       ack_d;
  logic             we_q;
  logic             we_d;
  logic             busy_q;
  logic             busy_d;
  logic [15:0]      data_q;
  logic [1:0]       owner_q;

  assign grant    = |bus.req;
  assign sel_word = bus.req_data[{sel, 4'b0000} +: 16];

  // Circular search starting just after the last winner keeps a persistent
  // requester from starving the others.
  always_comb begin
    sel   = last + 2'd1;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = last + 2'd1 + 2'(i);
      if (!found && bus.req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = WRITE;
      WRITE:   state_next = HOLD;
      HOLD:    if (cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values are decoded one cycle early so every port comes from a flop.
  always_comb begin
    we_d   = (state_next == WRITE);
    busy_d = (state_next != IDLE);
    ack_d  = we_d ? (4'b0001 << sel) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      ack_q   <= 4'b0000;
      busy_q  <= 1'b0;
      data_q  <= 16'h0000;
      owner_q <= 2'd0;
      last    <= 2'd3;
      cnt     <= '0;
    end else begin
      we_q   <= we_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
      case (state)
        IDLE: begin
          if (grant) begin
            owner_q <= sel;
            last    <= sel;
            data_q  <= sel_word;
          end
        end
        WRITE:   cnt <= CNT_LOAD;
        HOLD:    if (cnt != '0) cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.disp_we   = we_q;
  assign bus.disp_data = data_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;

endmodule
